// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the UART-command Wishbone master.
// Holds the FSM encoding, ASCII command/response codes and the nibble-to-hex helper.
`timescale 1ns/1ps
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    REPLY = 2'd3
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  // Lowercase ASCII hex digit; 8'h57 is 'a' minus ten.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    if (nib < 4'd10)
      return 8'h30 + {4'h0, nib};
    else
      return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Decodes single-byte UART commands into one pipelined Wishbone transaction each
// and returns a one-byte ASCII status/result to the UART transmitter.
`timescale 1ns/1ps
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] WRITE_DATA = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_stb,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_busy,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic        o_addr,
  output logic [31:0] o_data,
  input  logic        i_stall,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  output logic        o_rx_overrun
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic          cyc_reg, cyc_next;
  logic          stb_reg, stb_next;
  logic          we_reg, we_next;
  logic [31:0]   data_reg, data_next;
  logic          tx_stb_reg, tx_stb_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          overrun_reg, overrun_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Only the low nibble of read data is reported.
  logic unused_data;
  assign unused_data = ^i_data[31:4];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      cyc_reg     <= 1'b0;
      stb_reg     <= 1'b0;
      we_reg      <= 1'b0;
      data_reg    <= '0;
      tx_stb_reg  <= 1'b0;
      tx_data_reg <= '0;
      overrun_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cyc_reg     <= cyc_next;
      stb_reg     <= stb_next;
      we_reg      <= we_next;
      data_reg    <= data_next;
      tx_stb_reg  <= tx_stb_next;
      tx_data_reg <= tx_data_next;
      overrun_reg <= overrun_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cyc_next     = cyc_reg;
    stb_next     = stb_reg;
    we_next      = we_reg;
    data_next    = data_reg;
    tx_stb_next  = tx_stb_reg;
    tx_data_next = tx_data_reg;
    overrun_next = 1'b0;
    cnt_next     = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (i_rx_stb && (i_rx_data == CMD_WR || i_rx_data == CMD_RD)) begin
          state_next = REQ;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          we_next    = (i_rx_data == CMD_WR);
          data_next  = (i_rx_data == CMD_WR) ? WRITE_DATA : 32'h0;
          cnt_next   = '0;
        end
      end

      REQ, WAIT: begin
        overrun_next = i_rx_stb;
        cnt_next     = cnt_reg + 1'b1;
        // An ack counts in REQ only when the strobe is accepted in the same cycle;
        // on the final counted cycle an ack still beats the timeout.
        if (i_ack && (state_reg == WAIT || !i_stall)) begin
          state_next   = REPLY;
          cyc_next     = 1'b0;
          stb_next     = 1'b0;
          tx_stb_next  = 1'b1;
          tx_data_next = we_reg ? RSP_OK : nib2hex(i_data[3:0]);
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = REPLY;
          cyc_next     = 1'b0;
          stb_next     = 1'b0;
          tx_stb_next  = 1'b1;
          tx_data_next = RSP_ERR;
        end else if (state_reg == REQ && !i_stall) begin
          state_next = WAIT;
          stb_next   = 1'b0;
        end
      end

      REPLY: begin
        overrun_next = i_rx_stb;
        if (!i_tx_busy) begin
          tx_stb_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign o_cyc        = cyc_reg;
  assign o_stb        = stb_reg;
  assign o_we         = we_reg;
  assign o_addr       = 1'b0;
  assign o_data       = data_reg;
  assign o_tx_stb     = tx_stb_reg;
  assign o_tx_data    = tx_data_reg;
  assign o_rx_overrun = overrun_reg;

`ifdef FORMAL
  a_stb_cyc: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    o_stb |-> o_cyc);
  a_stall_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (o_stb && i_stall && !i_ack && cnt_reg != CNT_LAST)
      |=> (o_stb && $stable(o_we) && $stable(o_data) && $stable(o_addr)));
  a_one_outstanding: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (o_cyc && !o_stb) |=> !o_stb);
  a_tx_hold: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (o_tx_stb && i_tx_busy) |=> (o_tx_stb && $stable(o_tx_data)));
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: the bench plays the UART and the Wishbone slave
// and compares DUT outputs against hand-computed values.
`timescale 1ns/1ps
module tb_wb_cmd_master;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_rx_stb;
  logic [7:0]  i_rx_data;
  logic        o_tx_stb;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic        o_cyc;
  logic        o_stb;
  logic        o_we;
  logic        o_addr;
  logic [31:0] o_data;
  logic        i_stall;
  logic        i_ack;
  logic [31:0] i_data;
  logic        o_rx_overrun;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  int req_cnt = 0;
  int base_acc;
  int base_req;
  int n;

  wb_cmd_master #(.TIMEOUT(64), .WRITE_DATA(32'h0)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_rx_stb     (i_rx_stb),
    .i_rx_data    (i_rx_data),
    .o_tx_stb     (o_tx_stb),
    .o_tx_data    (o_tx_data),
    .i_tx_busy    (i_tx_busy),
    .o_cyc        (o_cyc),
    .o_stb        (o_stb),
    .o_we         (o_we),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .i_stall      (i_stall),
    .i_ack        (i_ack),
    .i_data       (i_data),
    .o_rx_overrun (o_rx_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Count UART accepts and Wishbone request accepts as seen by the bench.
  always @(posedge i_clk) begin
    if (i_reset_n && o_tx_stb && !i_tx_busy) accept_cnt <= accept_cnt + 1;
    if (i_reset_n && o_stb && !i_stall)      req_cnt    <= req_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_stb  = 1'b1;
    i_rx_data = b;
    tick();
    i_rx_stb  = 1'b0;
    i_rx_data = 8'h00;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_rx_stb  = 1'b0;
    i_rx_data = 8'h00;
    i_tx_busy = 1'b0;
    i_stall   = 1'b0;
    i_ack     = 1'b0;
    i_data    = 32'h0;
    tick(); tick();
    check("rst_cyc", {31'b0, o_cyc}, 32'd0);
    check("rst_stb", {31'b0, o_stb}, 32'd0);
    check("rst_tx_stb", {31'b0, o_tx_stb}, 32'd0);
    check("rst_tx_data", {24'b0, o_tx_data}, 32'h00);
    check("rst_overrun", {31'b0, o_rx_overrun}, 32'd0);
    i_reset_n = 1'b1;
    tick();

    // 1: write, no stall, ack one cycle after request accept
    base_acc = accept_cnt;
    send_byte(8'h57);
    check("w_stb", {31'b0, o_stb}, 32'd1);
    check("w_cyc", {31'b0, o_cyc}, 32'd1);
    check("w_we", {31'b0, o_we}, 32'd1);
    check("w_data", o_data, 32'h0);
    check("w_addr", {31'b0, o_addr}, 32'd0);
    tick();
    check("w_wait_stb", {31'b0, o_stb}, 32'd0);
    check("w_wait_cyc", {31'b0, o_cyc}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("w_ack_cyc", {31'b0, o_cyc}, 32'd0);
    check("w_reply_stb", {31'b0, o_tx_stb}, 32'd1);
    check("w_reply_data", {24'b0, o_tx_data}, 32'h4B);
    tick();
    check("w_reply_done", {31'b0, o_tx_stb}, 32'd0);
    check("w_accepts", accept_cnt - base_acc, 32'd1);

    // 2a: read with ack in WAIT, i_data=0xb -> 'b'
    send_byte(8'h52);
    check("r_we", {31'b0, o_we}, 32'd0);
    tick();
    i_ack = 1'b1; i_data = 32'hFFFF_FF0B;
    tick();
    i_ack = 1'b0; i_data = 32'h0;
    check("r_b_data", {24'b0, o_tx_data}, 32'h62);
    tick();
    // 2b: read with ack in the same cycle the request is accepted, i_data=5 -> '5'
    send_byte(8'h52);
    i_ack = 1'b1; i_data = 32'h0000_0005;
    tick();
    i_ack = 1'b0; i_data = 32'h0;
    check("r_5_cyc", {31'b0, o_cyc}, 32'd0);
    check("r_5_stb", {31'b0, o_tx_stb}, 32'd1);
    check("r_5_data", {24'b0, o_tx_data}, 32'h35);
    tick();

    // 3: write with 3 stall cycles
    base_acc = accept_cnt;
    base_req = req_cnt;
    i_stall = 1'b1;
    send_byte(8'h57);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_stb%0d", k), {31'b0, o_stb}, 32'd1);
      check($sformatf("stall_we%0d", k), {31'b0, o_we}, 32'd1);
      check($sformatf("stall_data%0d", k), o_data, 32'h0);
      if (k == 2) i_stall = 1'b0;
      tick();
    end
    check("stall_after_stb", {31'b0, o_stb}, 32'd0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("stall_reply", {24'b0, o_tx_data}, 32'h4B);
    tick();
    check("stall_accepts", accept_cnt - base_acc, 32'd1);
    check("stall_reqs", req_cnt - base_req, 32'd1);

    // 4: read, never acked -> 'E' after 64 cycles
    send_byte(8'h52);
    n = 0;
    while (o_cyc && n < 200) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 32'd64);
    check("tmo_tx_stb", {31'b0, o_tx_stb}, 32'd1);
    check("tmo_data", {24'b0, o_tx_data}, 32'h45);
    tick();

    // 5: unknown byte ignored; command during WAIT overruns
    base_acc = accept_cnt;
    base_req = req_cnt;
    send_byte(8'h58);
    check("x_cyc", {31'b0, o_cyc}, 32'd0);
    check("x_overrun", {31'b0, o_rx_overrun}, 32'd0);
    tick(); tick();
    check("x_tx_stb", {31'b0, o_tx_stb}, 32'd0);
    send_byte(8'h57);
    tick();
    send_byte(8'h57);
    check("ovr_pulse", {31'b0, o_rx_overrun}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("ovr_clear", {31'b0, o_rx_overrun}, 32'd0);
    check("ovr_reply", {24'b0, o_tx_data}, 32'h4B);
    tick(); tick(); tick();
    check("ovr_reqs", req_cnt - base_req, 32'd1);
    check("ovr_accepts", accept_cnt - base_acc, 32'd1);
    check("ovr_idle_cyc", {31'b0, o_cyc}, 32'd0);

    // 6a: transmitter busy for 10 cycles in REPLY
    base_acc = accept_cnt;
    send_byte(8'h52);
    tick();
    i_tx_busy = 1'b1;
    i_ack = 1'b1; i_data = 32'h0000_000F;
    tick();
    i_ack = 1'b0; i_data = 32'h0;
    for (int k = 0; k < 10; k++) begin
      if (o_tx_stb !== 1'b1 || o_tx_data !== 8'h66)
        check($sformatf("busy_hold%0d", k), {23'b0, o_tx_stb, o_tx_data}, {23'b0, 1'b1, 8'h66});
      tick();
    end
    check("busy_held", {23'b0, o_tx_stb, o_tx_data}, {23'b0, 1'b1, 8'h66});
    i_tx_busy = 1'b0;
    tick();
    check("busy_done", {31'b0, o_tx_stb}, 32'd0);
    check("busy_accepts", accept_cnt - base_acc, 32'd1);

    // 6b: reset asserted while waiting for ack
    send_byte(8'h57);
    tick();
    check("rw_pre_cyc", {31'b0, o_cyc}, 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("rw_async_cyc", {31'b0, o_cyc}, 32'd0);
    check("rw_async_stb", {31'b0, o_stb}, 32'd0);
    tick();
    i_reset_n = 1'b1;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick(); tick();
    check("rw_no_reply", {31'b0, o_tx_stb}, 32'd0);
    check("rw_idle_cyc", {31'b0, o_cyc}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
